// File: rtl/unencoded_tcam_pkg.sv
// -----------------------------------------------------------------------------
// unencoded_tcam_pkg
// Shared types and helpers for the unencoded ternary CAM:
//   - state_t     : controller FSM encoding (INIT sweep, IDLE, HOLD after write)
//   - BUSY_CNT_W  : width of the post-write busy counter (BUSY_CYCLES <= 15)
//   - clog2()     : address width helper, never returns less than 1
// -----------------------------------------------------------------------------
package unencoded_tcam_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int BUSY_CNT_W = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/unencoded_tcam_if.sv
// -----------------------------------------------------------------------------
// unencoded_tcam_if
// Lookup + write bus of the unencoded TCAM.
//   master : lookup key/mask, write strobe/address/data/mask; sees results
//   slave  : the CAM itself; drives cam_busy, cam_match, cam_match_addr,
//            wr_dropped
// -----------------------------------------------------------------------------
interface unencoded_tcam_if
    import unencoded_tcam_pkg::*;
#(
    parameter int CMP_WIDTH      = 32,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = clog2(LUT_DEPTH)
);
    logic [CMP_WIDTH-1:0]      cam_cmp_din;
    logic [CMP_WIDTH-1:0]      cam_cmp_data_mask;
    logic                      cam_we;
    logic [LUT_DEPTH_BITS-1:0] cam_wr_addr;
    logic [CMP_WIDTH-1:0]      cam_din;
    logic [CMP_WIDTH-1:0]      cam_data_mask;
    logic                      cam_busy;
    logic                      cam_match;
    logic [LUT_DEPTH-1:0]      cam_match_addr;
    logic                      wr_dropped;

    modport master (
        output cam_cmp_din, cam_cmp_data_mask, cam_we, cam_wr_addr,
               cam_din, cam_data_mask,
        input  cam_busy, cam_match, cam_match_addr, wr_dropped
    );

    modport slave (
        input  cam_cmp_din, cam_cmp_data_mask, cam_we, cam_wr_addr,
               cam_din, cam_data_mask,
        output cam_busy, cam_match, cam_match_addr, wr_dropped
    );
endinterface

// File: rtl/unencoded_tcam_tcam_entry.sv
// -----------------------------------------------------------------------------
// tcam_entry
// One ternary CAM entry: valid bit, stored data and stored don't-care mask,
// plus its combinational compare against the lookup key.
//   clk, resetn : clock, synchronous active-low reset (clears valid only)
//   clr         : clear valid/data/mask (init sweep)
//   we          : write valid<=1, data<=wr_data, mask<=wr_mask
//   key         : lookup key
//   key_ign     : per-lookup ignore bits (1 = don't care)
//   match       : entry valid and all cared-for bits equal
// -----------------------------------------------------------------------------
module tcam_entry #(
    parameter int CMP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 we,
    input  logic [CMP_WIDTH-1:0] wr_data,
    input  logic [CMP_WIDTH-1:0] wr_mask,
    input  logic [CMP_WIDTH-1:0] key,
    input  logic [CMP_WIDTH-1:0] key_ign,
    output logic                 match
);
    logic                 valid;
    logic [CMP_WIDTH-1:0] data;
    logic [CMP_WIDTH-1:0] mask;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (we) begin
            valid <= 1'b1;
        end
    end

    // NOTE: data/mask carry no reset; valid gates every compare, and the init
    // sweep that follows each reset zeroes them one entry per cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            data <= '0;
            mask <= '0;
        end else if (we) begin
            data <= wr_data;
            mask <= wr_mask;
        end
    end

    assign match = valid && (((data ^ key) & ~mask & ~key_ign) == '0);

endmodule

// File: rtl/unencoded_tcam.sv
// -----------------------------------------------------------------------------
// unencoded_tcam
// Register-based ternary CAM returning a multi-hot (unencoded) match vector,
// one cycle after the key is presented. Replaces a vendor CAM core under the
// output-port lookup state machine.
//   clk     : clock, all logic on rising edge
//   resetn  : synchronous active-low reset; restarts the init sweep
//   bus     : unencoded_tcam_if.slave (lookup key/mask, single-entry write,
//             cam_busy, cam_match, cam_match_addr, wr_dropped)
// Build option: define UNENCODED_TCAM_CMP_DMASK_EN to let cam_cmp_data_mask
// take part in the compare; otherwise that input is ignored.
// -----------------------------------------------------------------------------
module unencoded_tcam
    import unencoded_tcam_pkg::*;
#(
    parameter int CMP_WIDTH      = 32,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = clog2(LUT_DEPTH),
    parameter int BUSY_CYCLES    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    unencoded_tcam_if.slave   bus
);
    localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

    state_t                    state, state_next;
    logic [LUT_DEPTH_BITS-1:0] init_idx, init_idx_next;
    logic [BUSY_CNT_W-1:0]     busy_cnt, busy_cnt_next;

    logic                      addr_ok;
    logic                      accept;
    logic                      drop;
    logic                      busy;
    logic [LUT_DEPTH-1:0]      entry_clr;
    logic [LUT_DEPTH-1:0]      entry_we;
    logic [LUT_DEPTH-1:0]      match_vec;
    logic [CMP_WIDTH-1:0]      key_ign;

    logic [LUT_DEPTH-1:0]      match_addr_q;
    logic                      match_q;
    logic                      wr_dropped_q;

`ifdef UNENCODED_TCAM_CMP_DMASK_EN
    assign key_ign = bus.cam_cmp_data_mask;
`else
    logic unused_cmp_data_mask;
    assign unused_cmp_data_mask = ^bus.cam_cmp_data_mask;
    assign key_ign = '0;
`endif

    // Non-power-of-two depths leave addresses with no entry behind them.
    assign addr_ok = int'(bus.cam_wr_addr) < LUT_DEPTH;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_INIT;
            init_idx <= '0;
            busy_cnt <= '0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
            busy_cnt <= busy_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        busy_cnt_next = busy_cnt;
        unique case (state)
            ST_INIT: begin
                init_idx_next = init_idx + 1'b1;
                if (init_idx == LAST_IDX) begin
                    state_next    = ST_IDLE;
                    init_idx_next = '0;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_next    = ST_HOLD;
                    busy_cnt_next = BUSY_CNT_W'(BUSY_CYCLES);
                end
            end
            ST_HOLD: begin
                busy_cnt_next = busy_cnt - 1'b1;
                if (busy_cnt == BUSY_CNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // A write during reset is not accepted, so no entry is ever half-written.
    always_comb begin
        busy   = (state != ST_IDLE);
        accept = resetn && bus.cam_we && (state == ST_IDLE) && addr_ok;
        drop   = bus.cam_we && !accept;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            entry_clr[i] = (state == ST_INIT) && (init_idx == LUT_DEPTH_BITS'(i));
            entry_we[i]  = accept && (bus.cam_wr_addr == LUT_DEPTH_BITS'(i));
        end
    end

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_entry
        tcam_entry #(
            .CMP_WIDTH (CMP_WIDTH)
        ) u_entry (
            .clk     (clk),
            .resetn  (resetn),
            .clr     (entry_clr[i]),
            .we      (entry_we[i]),
            .wr_data (bus.cam_din),
            .wr_mask (bus.cam_data_mask),
            .key     (bus.cam_cmp_din),
            .key_ign (key_ign),
            .match   (match_vec[i])
        );
    end

    // Compare results are registered; they read entry contents from before
    // any write on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            match_addr_q <= '0;
            match_q      <= 1'b0;
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= drop;
            if (state == ST_INIT) begin
                match_addr_q <= '0;
                match_q      <= 1'b0;
            end else begin
                match_addr_q <= match_vec;
                match_q      <= |match_vec;
            end
        end
    end

    assign bus.cam_busy       = busy;
    assign bus.cam_match      = match_q;
    assign bus.cam_match_addr = match_addr_q;
    assign bus.wr_dropped     = wr_dropped_q;

endmodule

// File: tb/tb_unencoded_tcam.sv
// -----------------------------------------------------------------------------
// tb_unencoded_tcam
// Self-checking bench for unencoded_tcam (BUSY_CYCLES = 3). A behavioural
// model of the entry table and busy window predicts each cycle's results;
// predictions are queued when stimulus is driven and compared on the
// following falling edge, after the DUT has registered its answer.
// -----------------------------------------------------------------------------
module tb_unencoded_tcam;
    import unencoded_tcam_pkg::*;

    localparam int CW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int BUSY  = 3;

    typedef struct {
        logic [DEPTH-1:0] vec;
        logic             m;
        logic             drop;
        logic             busy;
    } exp_t;

    logic clk;
    logic resetn;

    unencoded_tcam_if #(.CMP_WIDTH(CW), .LUT_DEPTH(DEPTH), .LUT_DEPTH_BITS(AW)) bus ();

    unencoded_tcam #(
        .CMP_WIDTH      (CW),
        .LUT_DEPTH      (DEPTH),
        .LUT_DEPTH_BITS (AW),
        .BUSY_CYCLES    (BUSY)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic        mv[DEPTH];
    logic [CW-1:0] md[DEPTH];
    logic [CW-1:0] mm[DEPTH];
    int          busy_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] model_match(input logic [CW-1:0] key,
                                                     input logic [CW-1:0] kmask);
        logic [DEPTH-1:0] v;
        logic [CW-1:0]    ign;
`ifdef UNENCODED_TCAM_CMP_DMASK_EN
        ign = kmask;
`else
        ign = '0;
`endif
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mv[i] && (((md[i] ^ key) & ~mm[i] & ~ign) == '0)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // One clock: drive at the falling edge, predict, let the DUT sample,
    // update the model, then compare at the next falling edge.
    task automatic cycle(input logic [CW-1:0] key, input logic [CW-1:0] kmask,
                         input logic we, input logic [AW-1:0] addr,
                         input logic [CW-1:0] din, input logic [CW-1:0] dmask);
        exp_t e;
        logic acc;
        bus.cam_cmp_din       = key;
        bus.cam_cmp_data_mask = kmask;
        bus.cam_we            = we;
        bus.cam_wr_addr       = addr;
        bus.cam_din           = din;
        bus.cam_data_mask     = dmask;
        acc    = we && (busy_left == 0);
        e.vec  = model_match(key, kmask);
        e.m    = |e.vec;
        e.drop = we && !acc;
        e.busy = acc || (busy_left > 1);
        sb.push_back(e);
        @(posedge clk);
        if (acc) begin
            mv[addr]  = 1'b1;
            md[addr]  = din;
            mm[addr]  = dmask;
            busy_left = BUSY;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(negedge clk);
        bus.cam_we = 1'b0;
        e = sb.pop_front();
        check("match_addr", bus.cam_match_addr, e.vec);
        check("match",      32'(bus.cam_match),  32'(e.m));
        check("wr_dropped", 32'(bus.wr_dropped), 32'(e.drop));
        check("busy",       32'(bus.cam_busy),   32'(e.busy));
    endtask

    task automatic lookup(input logic [CW-1:0] key, input logic [CW-1:0] kmask);
        cycle(key, kmask, 1'b0, '0, '0, '0);
    endtask

    task automatic write(input logic [AW-1:0] addr, input logic [CW-1:0] din,
                         input logic [CW-1:0] dmask, input logic [CW-1:0] key);
        cycle(key, '0, 1'b1, addr, din, dmask);
    endtask

    // Reset with a write pending, check reset values, then time the init sweep.
    task automatic do_reset();
        int n;
        bit zero_ok;
        @(negedge clk);
        resetn            = 1'b0;
        bus.cam_we        = 1'b1;
        bus.cam_wr_addr   = 5'd1;
        bus.cam_din       = 32'h0A000001;
        bus.cam_data_mask = '0;
        bus.cam_cmp_din   = 32'h0A000001;
        repeat (2) @(negedge clk);
        check("rst_busy",       32'(bus.cam_busy),   32'd1);
        check("rst_match",      32'(bus.cam_match),  32'd0);
        check("rst_match_addr", bus.cam_match_addr,  32'd0);
        check("rst_wr_dropped", 32'(bus.wr_dropped), 32'd0);
        bus.cam_we = 1'b0;
        resetn     = 1'b1;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        busy_left = 0;
        n = 1;
        zero_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 10) begin
                bus.cam_we      = 1'b1;
                bus.cam_wr_addr = 5'd2;
            end
            @(negedge clk);
            if (c == 10) begin
                check("init_drop", 32'(bus.wr_dropped), 32'd1);
                bus.cam_we = 1'b0;
            end
            if (bus.cam_match_addr != '0) zero_ok = 1'b0;
            if (!bus.cam_busy) break;
            n++;
        end
        check("init_busy_cycles", 32'(n), 32'd32);
        check("init_match_zero",  32'(zero_ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn                = 1'b0;
        bus.cam_cmp_din       = '0;
        bus.cam_cmp_data_mask = '0;
        bus.cam_we            = 1'b0;
        bus.cam_wr_addr       = '0;
        bus.cam_din           = '0;
        bus.cam_data_mask     = '0;

        do_reset();

        // Writes during reset and init must have left the table empty.
        lookup(32'h0A000001, '0);
        // Write entry 5 while looking up its value: old result this cycle.
        write(5'd5, 32'h0A000001, '0, 32'h0A000001);
        lookup(32'h0A000001, '0);                         // edge N+1: hit 0x20
        write(5'd7, 32'hDEADBEEF, '0, 32'h0A000002);      // edge N+2: dropped
        lookup(32'hDEADBEEF, '0);                         // entry 7 untouched
        write(5'd3, 32'h0A000000, 32'h000000FF, 32'h0A000001); // N+4: accepted
        repeat (3) lookup(32'h0A0000AB, '0);
        write(5'd7, 32'h0A000001, '0, 32'h0A000001);
        repeat (3) lookup(32'h0A000001, '0);
        // Reuse entry 5 with other data; entries 3 and 7 then match.
        write(5'd5, 32'h0B000000, '0, 32'h0A000001);
        repeat (3) lookup(32'h0A000001, '0);
        lookup(32'h0B000000, '0);
        // Lookup mask: 0x0A0000FF with ignore 0xFF hits exact entries only
        // when the option is built in.
        write(5'd0, 32'h0A000001, '0, '0);
        repeat (3) lookup(32'h0A000001, '0);
        lookup(32'h0A0000FF, 32'h000000FF);
        lookup(32'h0A0000FF, '0);

        // Random mix over a small key space so hits are frequent.
        for (int i = 0; i < 60; i++) begin
            cycle(32'h0A000000 | 32'($urandom_range(0, 3)),
                  32'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0),
                  AW'($urandom_range(0, DEPTH - 1)),
                  32'h0A000000 | 32'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 32'h3 : 32'h0);
        end

        // Reset in the middle of a hold window: table cleared, init restarts.
        repeat (3) lookup('0, '0);
        write(5'd9, 32'h12345678, '0, '0);
        do_reset();
        lookup(32'h12345678, '0);
        lookup(32'h0A000001, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
